// File: rtl/aes_inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes stage with optional InvShiftRows at capture.
// LANES inverse S-boxes process the 16-byte state over 16/LANES cycles;
// valid/ready handshakes on both sides, no overlap between blocks.
module aes_inv_sub_bytes_iter #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv_shift,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned N = 16 / LANES;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  // Inverse S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] InvSbox = {
    128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
    128'h547b9432_a6c2233d_ee4c950b_42fac34e, 128'h082ea166_28d924b2_765ba249_6d8bd125,
    128'h72f8f664_86689816_d4a45ccc_5d65b692, 128'h6c704850_fdedb9da_5e154657_a78d9d84,
    128'h90d8ab00_8cbcd30a_f7e45805_b8b34506, 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
    128'h3a911141_4f67dcea_97f2cfce_f0b4e673, 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
    128'h47f11a71_1d29c589_6fb7620e_aa18be1b, 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
    128'h1fdda833_8807c731_b1121059_2780ec5f, 128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
    128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961, 128'h172b047e_ba77d626_e1691463_55210c7d
  };

  typedef enum logic [1:0] {StIdle, StSub, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [127:0]    work_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [7:0]      sub_in  [LANES];
  logic [7:0]      sub_out [LANES];
  logic [127:0]    work_sub;
  logic [127:0]    work_load;

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return 8'(InvSbox >> (8 * (255 - 32'(x))));
  endfunction

  // Row r rotates right by r: result (r,c) takes input (r, (c-r) mod 4).
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned row = 0; row < 4; row++) begin
      for (int unsigned col = 0; col < 4; col++) begin
        r = r | (128'(8'(s >> (8 * (15 - (row + 4 * ((col + 4 - row) % 4))))))
                 << (8 * (15 - (row + 4 * col))));
      end
    end
    return r;
  endfunction

  // Select the LANES bytes addressed by the current count.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      sub_in[l] = 8'(work_q >> (8 * (15 - (32'(cnt_q) * LANES + l))));
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign sub_out[l] = inv_sbox(sub_in[l]);
  end

  // Merge substituted bytes back in place; other bytes hold.
  always_comb begin
    work_sub = work_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      work_sub = (work_sub & ~(128'hff << (8 * (15 - (32'(cnt_q) * LANES + l)))))
               | (128'(sub_out[l]) << (8 * (15 - (32'(cnt_q) * LANES + l))));
    end
  end

  // Capture value, with optional InvShiftRows.
  always_comb begin
    work_load = in_inv_shift ? inv_shift_rows(in_state) : in_state;
  end

  // Control FSM, counter, work register and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            work_q  <= work_load;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StSub;
          end
        end
        StSub: begin
          work_q <= work_sub;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_state = work_q;

endmodule

// File: tb/tb_aes_inv_sub_bytes_iter.sv
// Self-checking bench for aes_inv_sub_bytes_iter: reference model computes the
// inverse S-box from GF(2^8) arithmetic and InvShiftRows from byte positions.
module tb_aes_inv_sub_bytes_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv_shift;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  logic         alt_in_ready  [4];
  logic         alt_out_valid [4];
  logic         alt_busy      [4];
  logic [127:0] alt_out_state [4];

  int checks;
  int failures;

  aes_inv_sub_bytes_iter #(.LANES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_state     (in_state),
    .in_inv_shift (in_inv_shift),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_state    (out_state),
    .busy         (busy)
  );

  // Other lane counts share all inputs with the main instance.
  for (genvar g = 0; g < 4; g++) begin : g_alt
    aes_inv_sub_bytes_iter #(.LANES((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16)) u_alt (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (alt_in_ready[g]),
      .in_state     (in_state),
      .in_inv_shift (in_inv_shift),
      .out_valid    (alt_out_valid[g]),
      .out_ready    (out_ready),
      .out_state    (alt_out_state[g]),
      .busy         (alt_busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] c;
    if (a == 8'h00) return 8'h00;
    for (int i = 1; i < 256; i++) begin
      c = 8'(i);
      if (gmul(a, c) == 8'h01) return c;
    end
    return 8'h00;
  endfunction

  // InvSubBytes = GF inverse of the inverse affine transform.
  function automatic logic [7:0] ref_inv_sbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] s, input logic sh);
    logic [7:0]   bi [16];
    logic [7:0]   bo [16];
    logic [127:0] r;
    for (int k = 0; k < 16; k++) bi[k] = s[127 - 8 * k -: 8];
    for (int row = 0; row < 4; row++) begin
      for (int col = 0; col < 4; col++) begin
        bo[row + 4 * col] = sh ? bi[row + 4 * ((col - row + 4) % 4)] : bi[row + 4 * col];
      end
    end
    for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = ref_inv_sbox(bo[k]);
    return r;
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Called 1 time unit after a rising edge; returns cycles from accept to out_valid.
  task automatic run_block(input logic [127:0] s, input logic sh, output int lat,
                           output logic [127:0] got);
    int w;
    w = 0;
    in_state     = s;
    in_inv_shift = sh;
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    got = out_state;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: in_ready=%b out_valid=%b busy=%b required 0 0 0",
               in_ready, out_valid, busy);
    end
    checks++;
    if (out_state !== 128'h0) begin
      failures++;
      $display("FAIL reset_out_state: got %h required 0", out_state);
    end
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_in_ready: got %b required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_block();
    int lat;
    logic [127:0] got;
    run_block(128'h0, 1'b0, lat, got);
    checks++;
    if (lat !== 4) begin
      failures++;
      $display("FAIL zero_latency: got %0d required 4", lat);
    end
    checks++;
    if (got !== {16{8'h52}}) begin
      failures++;
      $display("FAIL zero_data: got %h required %h", got, {16{8'h52}});
    end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL zero_done_flags: busy=%b in_ready=%b required 1 0", busy, in_ready);
    end
    drain();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL zero_after_drain: in_ready=%b out_valid=%b busy=%b required 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_fips();
    int lat;
    logic [127:0] got;
    logic [127:0] exp_fips;
    exp_fips = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    run_block(128'h7ad5fda789ef4e272bca100b3d9ff59f, 1'b1, lat, got);
    checks++;
    if (got !== exp_fips) begin
      failures++;
      $display("FAIL fips_shift: got %h required %h", got, exp_fips);
    end
    drain();
    run_block(128'h7a9f102789d5f50b2beffd9f3dca4ea7, 1'b0, lat, got);
    checks++;
    if (got !== exp_fips) begin
      failures++;
      $display("FAIL fips_noshift: got %h required %h", got, exp_fips);
    end
    checks++;
    if (ref_block(128'h7ad5fda789ef4e272bca100b3d9ff59f, 1'b1) !== got) begin
      failures++;
      $display("FAIL fips_model_agree: dut %h model %h", got,
               ref_block(128'h7ad5fda789ef4e272bca100b3d9ff59f, 1'b1));
    end
    drain();
  endtask

  task automatic test_lanes();
    int           lat_main;
    int           alt_lat [4];
    logic [127:0] alt_got [4];
    logic [127:0] got_main;
    logic [127:0] exp_c;
    int           exp_lat [4];
    exp_lat = '{16, 8, 2, 1};
    exp_c   = {4{32'h52007d09}};
    pulse_reset();
    in_state     = {4{32'h0063ff01}};
    in_inv_shift = 1'b0;
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat_main = -1;
    got_main = '0;
    for (int g = 0; g < 4; g++) begin
      alt_lat[g] = -1;
      alt_got[g] = '0;
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid && lat_main < 0) begin
        lat_main = c;
        got_main = out_state;
      end
      for (int g = 0; g < 4; g++) begin
        if (alt_out_valid[g] && alt_lat[g] < 0) begin
          alt_lat[g] = c;
          alt_got[g] = alt_out_state[g];
        end
      end
    end
    checks++;
    if (lat_main !== 4 || got_main !== exp_c) begin
      failures++;
      $display("FAIL corner_lanes4: lat=%0d data=%h required lat=4 data=%h",
               lat_main, got_main, exp_c);
    end
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (alt_lat[g] !== exp_lat[g] || alt_got[g] !== exp_c) begin
        failures++;
        $display("FAIL corner_lanes_alt%0d: lat=%0d data=%h required lat=%0d data=%h",
                 g, alt_lat[g], alt_got[g], exp_lat[g], exp_c);
      end
    end
    drain();
  endtask

  task automatic test_random();
    int           lat;
    logic [127:0] got;
    logic [127:0] s;
    logic         sh;
    for (int i = 0; i < 8; i++) begin
      s  = {$urandom, $urandom, $urandom, $urandom};
      sh = 1'($urandom_range(0, 1));
      run_block(s, sh, lat, got);
      checks++;
      if (lat !== 4 || got !== ref_block(s, sh)) begin
        failures++;
        $display("FAIL random_%0d: in=%h shift=%b lat=%0d got=%h required lat=4 data=%h",
                 i, s, sh, lat, got, ref_block(s, sh));
      end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int           lat;
    logic [127:0] got;
    logic [127:0] s;
    logic [127:0] exp_s;
    s     = {$urandom, $urandom, $urandom, $urandom};
    exp_s = ref_block(s, 1'b1);
    run_block(s, 1'b1, lat, got);
    in_state = ~s;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_state !== exp_s || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL backpressure_hold_%0d: out_valid=%b out_state=%h in_ready=%b required 1 %h 0",
                 c, out_valid, out_state, in_ready, exp_s);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b required 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] a;
    logic [127:0] b;
    logic         sha;
    logic         shb;
    logic [127:0] outs [2];
    int           acc_cyc [2];
    int           n_acc;
    int           n_out;
    int           cyc;
    logic         acc;
    logic         xfer;
    logic [127:0] st;
    a   = {$urandom, $urandom, $urandom, $urandom};
    b   = {$urandom, $urandom, $urandom, $urandom};
    sha = 1'($urandom_range(0, 1));
    shb = ~sha;
    outs    = '{128'h0, 128'h0};
    acc_cyc = '{0, 0};
    n_acc = 0;
    n_out = 0;
    cyc   = 0;
    in_state     = a;
    in_inv_shift = sha;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    for (int i = 0; i < 40 && n_out < 2; i++) begin
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      st   = out_state;
      @(posedge clk); #1;
      cyc++;
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          in_state     = b;
          in_inv_shift = shb;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (xfer) begin
        outs[n_out] = st;
        n_out++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (n_acc !== 2 || (acc_cyc[1] - acc_cyc[0]) !== 6) begin
      failures++;
      $display("FAIL b2b_spacing: accepts=%0d spacing=%0d required 2 accepts spaced 6",
               n_acc, acc_cyc[1] - acc_cyc[0]);
    end
    checks++;
    if (n_out !== 2 || outs[0] !== ref_block(a, sha) || outs[1] !== ref_block(b, shb)) begin
      failures++;
      $display("FAIL b2b_data: outputs=%0d got %h %h required %h %h", n_out, outs[0],
               outs[1], ref_block(a, sha), ref_block(b, shb));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    int           w;
    int           lat;
    logic         seen_valid;
    logic [127:0] got;
    logic [127:0] s;
    w = 0;
    in_state     = {$urandom, $urandom, $urandom, $urandom};
    in_inv_shift = 1'b0;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;             // accept edge E0
    in_valid = 1'b0;
    @(posedge clk);                 // E1
    @(posedge clk); #2;             // E2: counter now 2
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_assert: busy=%b out_valid=%b in_ready=%b required 0 0 0",
               busy, out_valid, in_ready);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
    seen_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_no_output: out_valid seen=%b required 0", seen_valid);
    end
    s = {$urandom, $urandom, $urandom, $urandom};
    run_block(s, 1'b1, lat, got);
    checks++;
    if (lat !== 4 || got !== ref_block(s, 1'b1)) begin
      failures++;
      $display("FAIL midreset_next_block: lat=%0d got=%h required lat=4 data=%h",
               lat, got, ref_block(s, 1'b1));
    end
    drain();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_state     = '0;
    in_inv_shift = 1'b0;
    out_ready    = 1'b0;
    test_reset();
    test_zero_block();
    test_fips();
    test_lanes();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
